// File: rtl/jtag_tap_param.sv
// IEEE 1149.1-style TAP: 16-state FSM, instruction register, BYPASS/IDCODE/USER data registers.
// Latency: TDI reaches TDO after <selected register length> shift clocks; state and registers update on posedge TCK.
// No backpressure: TMS/TDI are consumed every TCK. Optional IDCODE register enabled by `define JTAG_TAP_IDCODE_EN.
module jtag_tap_param #(
    parameter int                  IR_WIDTH     = 4,
    parameter int                  DR_WIDTH     = 8,
    parameter logic [31:0]         IDCODE_VAL   = 32'h1000_0001,
    parameter logic [IR_WIDTH-1:0] INSTR_IDCODE = IR_WIDTH'(1),
    parameter logic [IR_WIDTH-1:0] INSTR_USER   = IR_WIDTH'(2)
) (
    input  logic                TCK,
    input  logic                TRST,
    input  logic                TMS,
    input  logic                TDI,
    output logic                TDO,
    output logic                TDO_EN,
    output logic [3:0]          state_obs,
    output logic [IR_WIDTH-1:0] ir_out,
    input  logic [DR_WIDTH-1:0] user_dr_in,
    output logic [DR_WIDTH-1:0] user_dr_out,
    output logic                user_update
);

    typedef enum logic [3:0] {
        TLR     = 4'h0,
        RTI     = 4'h1,
        SEL_DR  = 4'h2,
        CAP_DR  = 4'h3,
        SH_DR   = 4'h4,
        EX1_DR  = 4'h5,
        PAU_DR  = 4'h6,
        EX2_DR  = 4'h7,
        UPD_DR  = 4'h8,
        SEL_IR  = 4'h9,
        CAP_IR  = 4'hA,
        SH_IR   = 4'hB,
        EX1_IR  = 4'hC,
        PAU_IR  = 4'hD,
        EX2_IR  = 4'hE,
        UPD_IR  = 4'hF
    } tap_state_t;

    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);
`ifdef JTAG_TAP_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] IR_RESET = INSTR_IDCODE;
`else
    // Without an IDCODE register the safe default instruction is BYPASS.
    localparam logic [IR_WIDTH-1:0] IR_RESET = '1;
`endif

    tap_state_t state;
    tap_state_t state_nxt;

    logic [IR_WIDTH-1:0] ir_shift;
    logic [DR_WIDTH-1:0] user_shift;
    logic [DR_WIDTH-1:0] user_shifted;
    logic                bypass_reg;
    logic                sel_user;
    logic                sel_idcode;
    logic                idcode_tdo;

    // ------------------------------------------------------------------
    // TAP state machine
    // ------------------------------------------------------------------
    always_ff @(posedge TCK) begin
        if (TRST) begin
            state <= TLR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            TLR:    state_nxt = TMS ? TLR    : RTI;
            RTI:    state_nxt = TMS ? SEL_DR : RTI;
            SEL_DR: state_nxt = TMS ? SEL_IR : CAP_DR;
            CAP_DR: state_nxt = TMS ? EX1_DR : SH_DR;
            SH_DR:  state_nxt = TMS ? EX1_DR : SH_DR;
            EX1_DR: state_nxt = TMS ? UPD_DR : PAU_DR;
            PAU_DR: state_nxt = TMS ? EX2_DR : PAU_DR;
            EX2_DR: state_nxt = TMS ? UPD_DR : SH_DR;
            UPD_DR: state_nxt = TMS ? SEL_DR : RTI;
            SEL_IR: state_nxt = TMS ? TLR    : CAP_IR;
            CAP_IR: state_nxt = TMS ? EX1_IR : SH_IR;
            SH_IR:  state_nxt = TMS ? EX1_IR : SH_IR;
            EX1_IR: state_nxt = TMS ? UPD_IR : PAU_IR;
            PAU_IR: state_nxt = TMS ? EX2_IR : PAU_IR;
            EX2_IR: state_nxt = TMS ? UPD_IR : SH_IR;
            UPD_IR: state_nxt = TMS ? SEL_DR : RTI;
            default: state_nxt = TLR;
        endcase
    end

    assign state_obs = state;
    assign TDO_EN    = (state == SH_DR) || (state == SH_IR);

    // ------------------------------------------------------------------
    // Instruction register
    // ------------------------------------------------------------------
    always_ff @(posedge TCK) begin
        if (TRST) begin
            ir_shift <= '0;
            ir_out   <= IR_RESET;
        end else begin
            case (state)
                CAP_IR:  ir_shift <= IR_CAPTURE;
                SH_IR:   ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]};
                default: ir_shift <= ir_shift;
            endcase
            if (state == TLR) begin
                ir_out <= IR_RESET;
            end else if (state == UPD_IR) begin
                ir_out <= ir_shift;
            end
        end
    end

    // ------------------------------------------------------------------
    // Data register selection
    // ------------------------------------------------------------------
    assign sel_user = (ir_out == INSTR_USER);

`ifdef JTAG_TAP_IDCODE_EN
    logic [31:0] idcode_shift;

    assign sel_idcode = !sel_user && (ir_out == INSTR_IDCODE);
    assign idcode_tdo = idcode_shift[0];

    always_ff @(posedge TCK) begin
        if (TRST) begin
            idcode_shift <= '0;
        end else if (sel_idcode) begin
            if (state == CAP_DR) begin
                idcode_shift <= IDCODE_VAL;
            end else if (state == SH_DR) begin
                idcode_shift <= {TDI, idcode_shift[31:1]};
            end
        end
    end
`else
    logic unused_idcode;

    assign sel_idcode    = 1'b0;
    assign idcode_tdo    = 1'b0;
    assign unused_idcode = ^{IDCODE_VAL, INSTR_IDCODE};
`endif

    // ------------------------------------------------------------------
    // USER register (shift stage plus parallel update stage)
    // ------------------------------------------------------------------
    generate
        if (DR_WIDTH == 1) begin : g_user_narrow
            assign user_shifted = TDI;
        end else begin : g_user_wide
            assign user_shifted = {TDI, user_shift[DR_WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge TCK) begin
        if (TRST) begin
            user_shift <= '0;
        end else if (sel_user) begin
            if (state == CAP_DR) begin
                user_shift <= user_dr_in;
            end else if (state == SH_DR) begin
                user_shift <= user_shifted;
            end
        end
    end

    always_ff @(posedge TCK) begin
        if (TRST) begin
            user_dr_out <= '0;
        end else if ((state == UPD_DR) && sel_user) begin
            user_dr_out <= user_shift;
        end
    end

    assign user_update = (state == UPD_DR) && sel_user;

    // ------------------------------------------------------------------
    // BYPASS register: any opcode that is neither USER nor IDCODE
    // ------------------------------------------------------------------
    always_ff @(posedge TCK) begin
        if (TRST) begin
            bypass_reg <= 1'b0;
        end else if (!sel_user && !sel_idcode) begin
            if (state == CAP_DR) begin
                bypass_reg <= 1'b0;
            end else if (state == SH_DR) begin
                bypass_reg <= TDI;
            end
        end
    end

    // ------------------------------------------------------------------
    // TDO mux: driven only in the two shift states
    // ------------------------------------------------------------------
    always_comb begin
        TDO = 1'b0;
        if (state == SH_IR) begin
            TDO = ir_shift[0];
        end else if (state == SH_DR) begin
            if (sel_user) begin
                TDO = user_shift[0];
            end else if (sel_idcode) begin
                TDO = idcode_tdo;
            end else begin
                TDO = bypass_reg;
            end
        end
    end

endmodule

// File: tb/tb_jtag_tap_param.sv
// Bench for jtag_tap_param: table-driven TMS walk, directed scans, and randomized scans
// checked every cycle against a queue-based TAP model.
module tb_jtag_tap_param;

    localparam int IRW = 4;
    localparam int DRW = 8;
    localparam logic [IRW-1:0] ID_OP   = 4'h1;
    localparam logic [IRW-1:0] USER_OP = 4'h2;
    localparam logic [31:0]    IDCODE  = 32'h1000_0001;
`ifdef JTAG_TAP_IDCODE_EN
    localparam bit             ID_EN   = 1'b1;
    localparam logic [IRW-1:0] IR_RST  = 4'h1;
`else
    localparam bit             ID_EN   = 1'b0;
    localparam logic [IRW-1:0] IR_RST  = 4'hF;
`endif

    logic           TCK = 1'b0;
    logic           TRST = 1'b0;
    logic           TMS = 1'b1;
    logic           TDI = 1'b0;
    logic           TDO;
    logic           TDO_EN;
    logic [3:0]     state_obs;
    logic [IRW-1:0] ir_out;
    logic [DRW-1:0] user_dr_in = '0;
    logic [DRW-1:0] user_dr_out;
    logic           user_update;

    jtag_tap_param #(
        .IR_WIDTH    (IRW),
        .DR_WIDTH    (DRW),
        .IDCODE_VAL  (IDCODE),
        .INSTR_IDCODE(ID_OP),
        .INSTR_USER  (USER_OP)
    ) dut (
        .TCK        (TCK),
        .TRST       (TRST),
        .TMS        (TMS),
        .TDI        (TDI),
        .TDO        (TDO),
        .TDO_EN     (TDO_EN),
        .state_obs  (state_obs),
        .ir_out     (ir_out),
        .user_dr_in (user_dr_in),
        .user_dr_out(user_dr_out),
        .user_update(user_update)
    );

    always #5 TCK = ~TCK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Graph of the 1149.1 TAP as next-state tables indexed by state code.
    int nxt0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nxt1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

    int             m_state = 0;
    logic [IRW-1:0] m_ir    = IR_RST;
    logic [DRW-1:0] m_user  = '0;
    bit             m_ir_q[$];
    bit             m_dr_q[$];
    bit             chk_en  = 1'b0;

    task automatic model_edge(input bit trst, input bit tms, input bit tdi);
        if (trst) begin
            m_state = 0;
            m_ir    = IR_RST;
            m_user  = '0;
            m_ir_q.delete();
            for (int i = 0; i < IRW; i++) m_ir_q.push_back(1'b0);
            m_dr_q.delete();
            m_dr_q.push_back(1'b0);
        end else begin
            case (m_state)
                0: m_ir = IR_RST;
                3: begin
                    m_dr_q.delete();
                    if (m_ir == USER_OP)
                        for (int i = 0; i < DRW; i++) m_dr_q.push_back(user_dr_in[i]);
                    else if (ID_EN && m_ir == ID_OP)
                        for (int i = 0; i < 32; i++) m_dr_q.push_back(IDCODE[i]);
                    else
                        m_dr_q.push_back(1'b0);
                end
                4: begin
                    void'(m_dr_q.pop_front());
                    m_dr_q.push_back(tdi);
                end
                8: if (m_ir == USER_OP)
                       for (int i = 0; i < DRW; i++) m_user[i] = m_dr_q[i];
                10: begin
                    m_ir_q.delete();
                    for (int i = 0; i < IRW; i++) m_ir_q.push_back(i == 0);
                end
                11: begin
                    void'(m_ir_q.pop_front());
                    m_ir_q.push_back(tdi);
                end
                15: for (int i = 0; i < IRW; i++) m_ir[i] = m_ir_q[i];
                default: ;
            endcase
            m_state = tms ? nxt1[m_state] : nxt0[m_state];
        end
    endtask

    // ---------------- stepping ----------------
    bit s_tdo;
    bit s_upd;

    task automatic step(input bit trst, input bit tms, input bit tdi);
        bit exp_tdo;
        TRST = trst;
        TMS  = tms;
        TDI  = tdi;
        #1;
        s_tdo = TDO;
        s_upd = user_update;
        if (chk_en) begin
            exp_tdo = 1'b0;
            if (m_state == 4)  exp_tdo = m_dr_q[0];
            if (m_state == 11) exp_tdo = m_ir_q[0];
            chk("m_state",  64'(state_obs),   64'(m_state));
            chk("m_ir_out", 64'(ir_out),      64'(m_ir));
            chk("m_user",   64'(user_dr_out), 64'(m_user));
            chk("m_tdo_en", 64'(TDO_EN),      64'(m_state == 4 || m_state == 11));
            chk("m_tdo",    64'(TDO),         64'(exp_tdo));
            chk("m_update", 64'(user_update), 64'(m_state == 8 && m_ir == USER_OP));
        end
        @(posedge TCK);
        model_edge(trst, tms, tdi);
        if (trst) chk_en = 1'b1;
        @(negedge TCK);
    endtask

    task automatic goto_rti();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    // Both scans start and end in RTI.
    task automatic ir_scan(input logic [IRW-1:0] din, output logic [IRW-1:0] dout);
        dout = '0;
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < IRW; i++) begin
            step(1'b0, i == IRW - 1, din[i]);
            dout[i] = s_tdo;
        end
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    bit upd_hist[3];

    task automatic dr_scan(input int n, input logic [63:0] din, output logic [63:0] dout);
        dout = '0;
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            step(1'b0, i == n - 1, din[i]);
            dout[i] = s_tdo;
        end
        step(1'b0, 1'b1, 1'b0);
        upd_hist[0] = s_upd;
        step(1'b0, 1'b0, 1'b0);
        upd_hist[1] = s_upd;
        step(1'b0, 1'b0, 1'b0);
        upd_hist[2] = s_upd;
    endtask

    // ---------------- TMS walk table ----------------
    typedef struct {
        bit         trst;
        bit         tms;
        logic [3:0] exp_state;
        bit         exp_en;
    } vec_t;

    localparam int NV = 38;
    vec_t vt[NV];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [63:0]    dout;
        logic [IRW-1:0] iout;
        logic [63:0]    din;

        vt = '{
            '{1, 1, 4'h0, 0}, '{0, 0, 4'h1, 0}, '{0, 1, 4'h2, 0}, '{0, 0, 4'h3, 0},
            '{0, 0, 4'h4, 1}, '{0, 1, 4'h5, 0}, '{0, 1, 4'h8, 0}, '{0, 1, 4'h2, 0},
            '{0, 1, 4'h9, 0}, '{0, 1, 4'h0, 0}, '{0, 1, 4'h0, 0}, '{0, 0, 4'h1, 0},
            '{0, 0, 4'h1, 0}, '{0, 1, 4'h2, 0}, '{0, 1, 4'h9, 0}, '{0, 0, 4'hA, 0},
            '{0, 0, 4'hB, 1}, '{0, 1, 4'hC, 0}, '{0, 0, 4'hD, 0}, '{0, 1, 4'hE, 0},
            '{0, 0, 4'hB, 1}, '{0, 1, 4'hC, 0}, '{0, 1, 4'hF, 0}, '{0, 1, 4'h2, 0},
            '{0, 0, 4'h3, 0}, '{0, 1, 4'h5, 0}, '{0, 0, 4'h6, 0}, '{0, 1, 4'h7, 0},
            '{0, 0, 4'h4, 1}, '{0, 1, 4'h5, 0}, '{0, 1, 4'h8, 0}, '{0, 1, 4'h2, 0},
            '{0, 1, 4'h9, 0}, '{0, 1, 4'h0, 0}, '{0, 0, 4'h1, 0}, '{0, 1, 4'h2, 0},
            '{0, 0, 4'h3, 0}, '{1, 0, 4'h0, 0}
        };

        // T2: table-driven TMS walk, including a TRST in Capture_DR
        for (int i = 0; i < NV; i++) begin
            step(vt[i].trst, vt[i].tms, 1'b0);
            chk("walk_state",  64'(state_obs), 64'(vt[i].exp_state));
            chk("walk_tdo_en", 64'(TDO_EN),    64'(vt[i].exp_en));
        end

        // T1: reset state
        step(1'b1, 1'b0, 1'b0);
        chk("rst_state",  64'(state_obs),   64'h0);
        chk("rst_ir",     64'(ir_out),      64'(IR_RST));
        chk("rst_user",   64'(user_dr_out), 64'h0);
        chk("rst_tdo_en", 64'(TDO_EN),      64'h0);
        chk("rst_tdo",    64'(TDO),         64'h0);

        // T3: first DR scan after reset: IDCODE, or BYPASS delay-by-one
        step(1'b0, 1'b0, 1'b0);
        din = {32'h0, 32'hC3A5_96E1};
        dr_scan(32, din, dout);
        if (ID_EN) chk("idcode_scan", 64'(dout[31:0]), 64'(IDCODE));
        else       chk("bypass_after_reset", 64'(dout[31:0]), 64'({din[30:0], 1'b0}));
        chk("idcode_no_update", 64'(upd_hist[1]), 64'h0);

        // T4: IR capture pattern and load of USER
        ir_scan(USER_OP, iout);
        chk("ir_capture", 64'(iout),   64'h1);
        chk("ir_load",    64'(ir_out), 64'(USER_OP));

        // T5: USER capture/shift/update and one-cycle strobe
        user_dr_in = 8'hA5;
        dr_scan(DRW, 64'h3C, dout);
        chk("user_tdo",      64'(dout[DRW-1:0]), 64'hA5);
        chk("user_out",      64'(user_dr_out),   64'h3C);
        chk("user_upd_ex1",  64'(upd_hist[0]),   64'h0);
        chk("user_upd_upd",  64'(upd_hist[1]),   64'h1);
        chk("user_upd_post", 64'(upd_hist[2]),   64'h0);

        // Capture -> Exit1 -> Update with no shift loads the captured value
        user_dr_in = 8'h5A;
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("noshift_update", 64'(user_dr_out), 64'h5A);

        // Five TMS=1 reach TLR; TLR restores the default instruction
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
        chk("five_ones_state", 64'(state_obs), 64'h0);
        step(1'b0, 1'b0, 1'b0);
        chk("tlr_forces_ir", 64'(ir_out), 64'(IR_RST));

        // T6: all-ones opcode is BYPASS; TRST mid-scan
        ir_scan(4'hF, iout);
        chk("bypass_ir", 64'(ir_out), 64'hF);
        dr_scan(3, 64'b101, dout);
        chk("bypass_tdo", 64'(dout[2:0]), 64'b010);
        ir_scan(USER_OP, iout);
        user_dr_in = 8'h77;
        dr_scan(DRW, 64'hE1, dout);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("midscan_pre_en", 64'(TDO_EN), 64'h1);
        step(1'b1, 1'b0, 1'b0);
        chk("midscan_state", 64'(state_obs),   64'h0);
        chk("midscan_ir",    64'(ir_out),      64'(IR_RST));
        chk("midscan_user",  64'(user_dr_out), 64'h0);

        // Randomized scans and TMS noise against the model
        for (int it = 0; it < 40; it++) begin
            logic [IRW-1:0] op;
            int             nn;
            goto_rti();
            case ($urandom_range(0, 3))
                0:       op = ID_OP;
                1:       op = USER_OP;
                2:       op = 4'hF;
                default: op = IRW'($urandom);
            endcase
            ir_scan(op, iout);
            user_dr_in = DRW'($urandom);
            dr_scan($urandom_range(1, 40), {$urandom, $urandom}, dout);
            nn = $urandom_range(0, 15);
            for (int k = 0; k < nn; k++)
                step($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
